fifo_buffer_param: RTL and testbench
====================================

Name: fifo_buffer_param

Overview:
Parametrised synchronous FIFO; successor to the fixed 16x8 buffer. Generic data width and depth. Correct count tracking on simultaneous read/write. Adds almost-full/almost-empty thresholds, fill level, sticky overflow/underflow flags, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Used as the standard single-clock buffer between producer/consumer blocks in the memory subsystem.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, ALMOST_FULL asserted when level >= AF_THRESH
AE_THRESH, 2, ALMOST_EMPTY asserted when level <= AE_THRESH
FWFT, 0, 0 = standard registered read (1-cycle latency); 1 = show-ahead head word

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst_n  in  1  synchronous reset, active low
CLR  in  1  synchronous flush: empties FIFO, keeps error flags
WR  in  1  write request
dataIn  in  DATA_W  write data
RD  in  1  read request (pop in FWFT mode)
dataOut  out  DATA_W  read data
VALID  out  1  dataOut holds a newly read word (standard mode) / head word present (FWFT)
FULL  out  1  level == DEPTH
EMPTY  out  1  level == 0
ALMOST_FULL  out  1  level >= AF_THRESH
ALMOST_EMPTY  out  1  level <= AE_THRESH
LEVEL  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
OVERFLOW  out  1  sticky: WR seen while FULL
UNDERFLOW  out  1  sticky: RD seen while EMPTY

Behaviour:
- Reset (Rst_n=0 at edge): pointers, LEVEL=0, dataOut=0, VALID=0, OVERFLOW=0, UNDERFLOW=0; so FULL=0, EMPTY=1, ALMOST_EMPTY=1, ALMOST_FULL=0. Memory array not reset. Reset has priority over CLR, WR, RD; asserted mid-transfer it discards all contents.
- CLR=1 (Rst_n=1): pointers and LEVEL to 0, VALID=0, dataOut held; WR/RD that cycle ignored; OVERFLOW/UNDERFLOW unchanged.
- Write accepted iff WR && !FULL: mem[wr_ptr] <= dataIn, wr_ptr+1 mod DEPTH.
- Read accepted iff RD && !EMPTY: rd_ptr+1 mod DEPTH.
- Acceptance judged on pre-edge FULL/EMPTY. WR while FULL: dropped, OVERFLOW<=1. RD while EMPTY: no pointer change, UNDERFLOW<=1. Both sticky until reset.
- LEVEL next = LEVEL + wr_acc - rd_acc. Simultaneous accepted read+write: LEVEL unchanged, both pointers advance. When FULL, simultaneous WR+RD: read accepted, write dropped (OVERFLOW set). When EMPTY, simultaneous WR+RD: write accepted, read rejected (UNDERFLOW set); no write-through bypass.
- Pointers are $clog2(DEPTH) bits, natural wrap. FULL/EMPTY/ALMOST_* decoded combinationally from registered LEVEL (no extra latency).
- Standard mode (FWFT=0): on accepted read, dataOut <= mem[rd_ptr] and VALID<=1 next cycle; otherwise VALID<=0 and dataOut holds last value.
- FWFT mode (FWFT=1): dataOut = mem[rd_ptr] combinationally, VALID = !EMPTY; RD pops current head; next head visible the cycle after the pop. Written word visible the cycle after its write. dataOut is don't-care while EMPTY.
- Thresholds checked at elaboration: 0 < AE_THRESH < AF_THRESH <= DEPTH, else $error.

Decomposition:
- Package fifo_pkg: level-width helper function (clog2-based), FIFO error-flag struct {overflow, underflow} shared with other buffers.
- Sub-module fifo_mem: DEPTH x DATA_W register array, one write port, one asynchronous read port; top holds pointers, level, flags, output register.

Test Plan:
- Reset/flags: Rst_n=0 one cycle -> LEVEL=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, dataOut=0, VALID=0, OVERFLOW=UNDERFLOW=0.
- Fill/drain (DATA_W=8, DEPTH=16, AF=14, AE=2, FWFT=0): write 0x00..0x0F -> ALMOST_EMPTY drops at LEVEL=3, ALMOST_FULL at 14, FULL at 16; 17th write -> OVERFLOW=1, LEVEL=16; 16 reads -> dataOut 0x00..0x0F, each one cycle after RD, VALID pulses.
- Wrap + simultaneous: preload 8, then 20 cycles WR=RD=1 with incrementing data -> LEVEL stays 8, output order preserved across pointer wrap.
- Boundary simultaneity: FULL with WR=RD=1 -> LEVEL=15, OVERFLOW=1; EMPTY with WR=RD=1 -> LEVEL=1, UNDERFLOW=1, no read data.
- FWFT=1: write 0xA5 -> next cycle dataOut=0xA5, VALID=1 with no RD; RD=1 pops, EMPTY=1 following cycle.
- CLR/reset mid-operation: LEVEL=9, OVERFLOW=1, CLR=1 -> LEVEL=0, EMPTY=1, OVERFLOW=1 retained; then Rst_n=0 -> OVERFLOW=0.

Source files
------------

// File: rtl/fifo_buffer_param_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the single-clock buffers of the memory subsystem.
//   level_w()     : width of a 0..depth occupancy count
//   fifo_err_t    : sticky error flags reported by every buffer
// ---------------------------------------------------------------------------
package fifo_pkg;

   // An occupancy count must reach depth itself, hence one bit beyond the
   // pointer width.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

endpackage

// File: rtl/fifo_buffer_param_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// ---------------------------------------------------------------------------
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array: written on the rising edge, never cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer_param.sv
// ---------------------------------------------------------------------------
// fifo_buffer_param
// Parametrised single-clock FIFO with level tracking, almost-full/empty
// thresholds, sticky overflow/underflow, synchronous flush and a selectable
// standard (registered, 1-cycle latency) or first-word-fall-through read.
// Ports:
//   Clk          : clock, all state updates on the rising edge
//   Rst_n        : synchronous reset, active low, highest priority
//   CLR          : synchronous flush, keeps error flags, ignores WR/RD
//   WR / dataIn  : write request and data
//   RD           : read request (pop in FWFT mode)
//   dataOut      : read data
//   VALID        : new word read (standard) / head word present (FWFT)
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY : decoded from LEVEL
//   LEVEL        : entry count 0..DEPTH
//   OVERFLOW     : sticky, WR while FULL
//   UNDERFLOW    : sticky, RD while EMPTY
// ---------------------------------------------------------------------------
module fifo_buffer_param
   import fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter bit FWFT      = 1'b0
) (
   input  logic                        Clk,
   input  logic                        Rst_n,
   input  logic                        CLR,
   input  logic                        WR,
   input  logic [DATA_W-1:0]           dataIn,
   input  logic                        RD,
   output logic [DATA_W-1:0]           dataOut,
   output logic                        VALID,
   output logic                        FULL,
   output logic                        EMPTY,
   output logic                        ALMOST_FULL,
   output logic                        ALMOST_EMPTY,
   output logic [$clog2(DEPTH):0]      LEVEL,
   output logic                        OVERFLOW,
   output logic                        UNDERFLOW
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_w(DEPTH);

   // Reject inconsistent configurations at elaboration time.
   if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
      $error("fifo_buffer_param: thresholds must satisfy 0 < AE_THRESH < AF_THRESH <= DEPTH");
   end
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_buffer_param: DEPTH must be a power of two and at least 4");
   end

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level_q;
   fifo_err_t         err_q;
   logic [DATA_W-1:0] mem_rdata;
   logic              full;
   logic              empty;
   logic              wr_acc;
   logic              rd_acc;

   // Status flags come straight from the registered level so they carry no
   // extra latency relative to LEVEL.
   assign full         = (level_q == LVL_W'(DEPTH));
   assign empty        = (level_q == '0);
   assign FULL         = full;
   assign EMPTY        = empty;
   assign ALMOST_FULL  = (level_q >= LVL_W'(AF_THRESH));
   assign ALMOST_EMPTY = (level_q <= LVL_W'(AE_THRESH));
   assign LEVEL        = level_q;
   assign OVERFLOW     = err_q.overflow;
   assign UNDERFLOW    = err_q.underflow;

   // Acceptance uses the pre-edge FULL/EMPTY; a flush cycle accepts nothing.
   // An empty FIFO never forwards the incoming word straight to the reader.
   assign wr_acc = WR && !full  && !CLR;
   assign rd_acc = RD && !empty && !CLR;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (Clk),
      .we    (wr_acc && Rst_n),
      .waddr (wr_ptr),
      .wdata (dataIn),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   // Pointer, level and error-flag bookkeeping. Reset clears everything
   // including the sticky flags; a flush empties the FIFO but leaves the
   // flags alone so an earlier error is still visible afterwards.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         err_q   <= '0;
      end else if (CLR) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level_q <= level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
         if (WR && full) begin
            err_q.overflow <= 1'b1;
         end
         if (RD && empty) begin
            err_q.underflow <= 1'b1;
         end
      end
   end

   if (FWFT) begin : g_fwft
      // Show-ahead: the head entry is always presented; it is meaningless
      // while the FIFO is empty.
      assign dataOut = mem_rdata;
      assign VALID   = !empty;
   end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      // Registered read: an accepted pop captures the head word and pulses
      // VALID for one cycle; otherwise the last word stays on dataOut.
      always_ff @(posedge Clk) begin
         if (!Rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else if (CLR) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
               dout_q <= mem_rdata;
            end
         end
      end

      assign dataOut = dout_q;
      assign VALID   = valid_q;
   end

endmodule

// File: tb/tb_fifo_buffer_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_buffer_param
// Drives a standard-mode and a FWFT-mode instance with identical stimulus
// and compares both against a queue-based model every cycle.
// ---------------------------------------------------------------------------
module tb_fifo_buffer_param;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          clk;
   logic          rst_n;
   logic          clr;
   logic          wr;
   logic          rd;
   logic [DW-1:0] din;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_valid, f_valid;
   logic          s_full, f_full, s_empty, f_empty;
   logic          s_af, f_af, s_ae, f_ae;
   logic [4:0]    s_level, f_level;
   logic          s_ovf, f_ovf, s_unf, f_unf;

   int compared   = 0;
   int mismatched = 0;

   // Model state
   logic [DW-1:0] q[$];
   logic          m_ovf, m_unf, m_valid;
   logic [DW-1:0] m_dout;

   fifo_buffer_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_std (
      .Clk(clk), .Rst_n(rst_n), .CLR(clr), .WR(wr), .dataIn(din), .RD(rd),
      .dataOut(s_dout), .VALID(s_valid), .FULL(s_full), .EMPTY(s_empty),
      .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae), .LEVEL(s_level),
      .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
   );

   fifo_buffer_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
      .Clk(clk), .Rst_n(rst_n), .CLR(clr), .WR(wr), .dataIn(din), .RD(rd),
      .dataOut(f_dout), .VALID(f_valid), .FULL(f_full), .EMPTY(f_empty),
      .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae), .LEVEL(f_level),
      .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare both DUTs against the model (called away from the clock edge).
   task automatic checkAll();
      int lvl;
      lvl = q.size();
      checkOutput("std.LEVEL",        32'(s_level), 32'(lvl));
      checkOutput("std.FULL",         32'(s_full),  32'(lvl == DEPTH));
      checkOutput("std.EMPTY",        32'(s_empty), 32'(lvl == 0));
      checkOutput("std.ALMOST_FULL",  32'(s_af),    32'(lvl >= AF));
      checkOutput("std.ALMOST_EMPTY", 32'(s_ae),    32'(lvl <= AE));
      checkOutput("std.OVERFLOW",     32'(s_ovf),   32'(m_ovf));
      checkOutput("std.UNDERFLOW",    32'(s_unf),   32'(m_unf));
      checkOutput("std.VALID",        32'(s_valid), 32'(m_valid));
      checkOutput("std.dataOut",      32'(s_dout),  32'(m_dout));
      checkOutput("fwft.LEVEL",       32'(f_level), 32'(lvl));
      checkOutput("fwft.FULL",        32'(f_full),  32'(lvl == DEPTH));
      checkOutput("fwft.EMPTY",       32'(f_empty), 32'(lvl == 0));
      checkOutput("fwft.OVERFLOW",    32'(f_ovf),   32'(m_ovf));
      checkOutput("fwft.UNDERFLOW",   32'(f_unf),   32'(m_unf));
      checkOutput("fwft.VALID",       32'(f_valid), 32'(lvl != 0));
      if (lvl != 0) begin
         checkOutput("fwft.dataOut", 32'(f_dout), 32'(q[0]));
      end
   endtask

   // Drive one cycle of inputs, advance the model by the same rules the
   // FIFO must obey, then let the edge happen and check half a cycle later.
   task automatic applyStimulus(input logic r_n, input logic c, input logic w,
                                input logic r, input logic [DW-1:0] d);
      logic was_full, was_empty;
      rst_n = r_n; clr = c; wr = w; rd = r; din = d;
      if (!r_n) begin
         q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;
      end else if (c) begin
         q.delete();
         m_valid = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (w && was_full)  m_ovf = 1'b1;
         if (r && was_empty) m_unf = 1'b1;
         if (r && !was_empty) begin
            m_dout  = q.pop_front();
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         if (w && !was_full) q.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
      checkAll();
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("pin.reset.LEVEL",   32'(s_level), 32'd0);
      checkOutput("pin.reset.EMPTY",   32'(s_empty), 32'd1);
      checkOutput("pin.reset.AE",      32'(s_ae),    32'd1);
      checkOutput("pin.reset.dataOut", 32'(s_dout),  32'd0);

      // Fill 0x00..0x0F, then one write too many
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
      checkOutput("pin.fill.LEVEL", 32'(s_level), 32'd16);
      checkOutput("pin.fill.FULL",  32'(s_full),  32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
      checkOutput("pin.ovf.OVERFLOW", 32'(s_ovf),   32'd1);
      checkOutput("pin.ovf.LEVEL",    32'(s_level), 32'd16);

      // Drain
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("pin.drain.dataOut", 32'(s_dout),  32'h00);
      checkOutput("pin.drain.VALID",   32'(s_valid), 32'd1);
      for (int i = 1; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("pin.drain.last", 32'(s_dout), 32'h0F);

      // Empty with WR=RD=1
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
      checkOutput("pin.emptyboth.LEVEL", 32'(s_level), 32'd1);
      checkOutput("pin.emptyboth.UNF",   32'(s_unf),   32'd1);
      checkOutput("pin.emptyboth.VALID", 32'(s_valid), 32'd0);

      // Full with WR=RD=1
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
      checkOutput("pin.fullboth.LEVEL", 32'(s_level), 32'd15);
      checkOutput("pin.fullboth.dout",  32'(s_dout),  32'h5A);

      // Wrap with simultaneous traffic
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++)  applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'(8'h88 + i));
      checkOutput("pin.wrap.LEVEL", 32'(s_level), 32'd8);
      checkOutput("pin.wrap.dout",  32'(s_dout),  32'h93);

      // FWFT show-ahead
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
      checkOutput("pin.fwft.dataOut", 32'(f_dout),  32'hA5);
      checkOutput("pin.fwft.VALID",   32'(f_valid), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("pin.fwft.EMPTY",   32'(f_empty), 32'd1);

      // Flush keeps flags, reset clears them
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
      for (int i = 0; i < 7; i++)  applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("pin.clr.pre", 32'(s_level), 32'd9);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
      checkOutput("pin.clr.LEVEL", 32'(s_level), 32'd0);
      checkOutput("pin.clr.OVF",   32'(s_ovf),   32'd1);
      checkOutput("pin.clr.dout",  32'(s_dout),  32'h06);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("pin.rst.OVF",   32'(s_ovf),   32'd0);

      // Randomised traffic with phases biased towards filling or draining
      for (int i = 0; i < 4000; i++) begin
         int wp, rp;
         logic r_n, c, w, r;
         wp = ((i / 150) % 2 == 0) ? 75 : 30;
         rp = 100 - wp;
         r_n = ($urandom_range(0, 399) != 0);
         c   = ($urandom_range(0, 99) == 0);
         w   = ($urandom_range(0, 99) < wp);
         r   = ($urandom_range(0, 99) < rp);
         applyStimulus(r_n, c, w, r, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
